// File: rtl/traffic_ctrl_2way.sv
// Two-approach intersection controller.
// Drives approach A/B lamps (active-low {G,B,R}), a pedestrian walk lamp and a
// debug phase code. It has fixed-length green/yellow/all-red phases, a latched
// pedestrian request served from all-red, and a night flashing-yellow mode
// that is entered only at the end of all-red.
module traffic_ctrl_2way #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned GREEN_CYC  = 100_000_000,
    parameter int unsigned YELLOW_CYC = 25_000_000,
    parameter int unsigned ALLRED_CYC = 10_000_000,
    parameter int unsigned PED_CYC    = 50_000_000,
    parameter int unsigned FLASH_CYC  = 13_500_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [2:0] led_a,
    output logic [2:0] led_b,
    output logic       ped_walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ST_ALLRED = 3'd0,
        ST_A_GRN  = 3'd1,
        ST_A_YEL  = 3'd2,
        ST_B_GRN  = 3'd3,
        ST_B_YEL  = 3'd4,
        ST_PED    = 3'd5,
        ST_FLASH  = 3'd6
    } state_e;

    // Active-low lamp encodings {G,B,R}
    localparam logic [2:0] LAMP_R   = 3'b110;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b011;
    localparam logic [2:0] LAMP_OFF = 3'b111;

    localparam logic DIR_A = 1'b0;
    localparam logic DIR_B = 1'b1;

    // Terminal counts: a phase of N cycles ends when cnt reaches N-1
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             next_dir_q, next_dir_d;
    logic             ped_pend_q, ped_pend_d;
    logic             flash_y_q, flash_y_d;

    logic             ped_s1_q, ped_s2_q, ped_prev_q;
    logic             night_s1_q, night_s2_q;
    logic             ped_rise_s;

    logic [2:0]       lamp_a_d, lamp_b_d;
    logic             walk_d;
    logic [2:0]       led_a_q, led_b_q, phase_q;
    logic             walk_q;

    assign ped_rise_s = ped_s2_q & ~ped_prev_q;

    // Two-flop synchronisers for the asynchronous button and switch, plus edge history
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ped_s1_q   <= 1'b0;
            ped_s2_q   <= 1'b0;
            ped_prev_q <= 1'b0;
            night_s1_q <= 1'b0;
            night_s2_q <= 1'b0;
        end else begin
            ped_s1_q   <= ped_req;
            ped_s2_q   <= ped_s1_q;
            ped_prev_q <= ped_s2_q;
            night_s1_q <= night_mode;
            night_s2_q <= night_s1_q;
        end
    end

    // Next-state, phase counter, direction, flash polarity and pedestrian latch
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_ONE;
        next_dir_d = next_dir_q;
        flash_y_d  = flash_y_q;
        ped_pend_d = ped_pend_q;

        case (state_q)
            ST_A_GRN: begin
                if (cnt_q == GREEN_LAST) begin
                    state_d = ST_A_YEL;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_A_GRN;
                end
            end
            ST_A_YEL: begin
                if (cnt_q == YELLOW_LAST) begin
                    state_d    = ST_ALLRED;
                    cnt_d      = CNT_ZERO;
                    next_dir_d = DIR_B;
                end else begin
                    state_d = ST_A_YEL;
                end
            end
            ST_B_GRN: begin
                if (cnt_q == GREEN_LAST) begin
                    state_d = ST_B_YEL;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_B_GRN;
                end
            end
            ST_B_YEL: begin
                if (cnt_q == YELLOW_LAST) begin
                    state_d    = ST_ALLRED;
                    cnt_d      = CNT_ZERO;
                    next_dir_d = DIR_A;
                end else begin
                    state_d = ST_B_YEL;
                end
            end
            ST_ALLRED: begin
                // Night mode and walk requests are only honoured here, so no
                // green or yellow is ever cut short.
                if (cnt_q == ALLRED_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (night_s2_q) begin
                        state_d   = ST_FLASH;
                        flash_y_d = 1'b1;
                    end else if (ped_pend_q) begin
                        state_d = ST_PED;
                    end else if (next_dir_q == DIR_A) begin
                        state_d = ST_A_GRN;
                    end else begin
                        state_d = ST_B_GRN;
                    end
                end else begin
                    state_d = ST_ALLRED;
                end
            end
            ST_PED: begin
                // Always hand over to a green so walk cannot repeat back-to-back
                if (cnt_q == PED_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (next_dir_q == DIR_A) begin
                        state_d = ST_A_GRN;
                    end else begin
                        state_d = ST_B_GRN;
                    end
                end else begin
                    state_d = ST_PED;
                end
            end
            ST_FLASH: begin
                if (!night_s2_q) begin
                    state_d    = ST_ALLRED;
                    cnt_d      = CNT_ZERO;
                    next_dir_d = DIR_A;
                end else if (cnt_q == FLASH_LAST) begin
                    cnt_d     = CNT_ZERO;
                    flash_y_d = ~flash_y_q;
                end else begin
                    state_d = ST_FLASH;
                end
            end
            default: begin
                state_d    = ST_ALLRED;
                cnt_d      = CNT_ZERO;
                next_dir_d = DIR_A;
            end
        endcase

        // Pedestrian latch: edges inside walk or flash are discarded; entering
        // walk or leaving flash clears it, and the clear wins over a new edge.
        if ((state_q != ST_PED) && (state_q != ST_FLASH) && ped_rise_s) begin
            ped_pend_d = 1'b1;
        end else begin
            ped_pend_d = ped_pend_q;
        end
        if ((state_d == ST_PED) && (state_q != ST_PED)) begin
            ped_pend_d = 1'b0;
        end else if ((state_q == ST_FLASH) && (state_d != ST_FLASH)) begin
            ped_pend_d = 1'b0;
        end else begin
            ped_pend_d = ped_pend_d;
        end
    end

    // Lamp decode from the upcoming state so registered outputs track the state register
    always_comb begin
        lamp_a_d = LAMP_R;
        lamp_b_d = LAMP_R;
        walk_d   = 1'b0;
        case (state_d)
            ST_A_GRN: lamp_a_d = LAMP_G;
            ST_A_YEL: lamp_a_d = LAMP_Y;
            ST_B_GRN: lamp_b_d = LAMP_G;
            ST_B_YEL: lamp_b_d = LAMP_Y;
            ST_PED:   walk_d   = 1'b1;
            ST_FLASH: begin
                if (flash_y_d) begin
                    lamp_a_d = LAMP_Y;
                    lamp_b_d = LAMP_Y;
                end else begin
                    lamp_a_d = LAMP_OFF;
                    lamp_b_d = LAMP_OFF;
                end
            end
            default: begin
                lamp_a_d = LAMP_R;
                lamp_b_d = LAMP_R;
                walk_d   = 1'b0;
            end
        endcase
    end

    // State, counter and control registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_ALLRED;
            cnt_q      <= CNT_ZERO;
            next_dir_q <= DIR_A;
            ped_pend_q <= 1'b0;
            flash_y_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            next_dir_q <= next_dir_d;
            ped_pend_q <= ped_pend_d;
            flash_y_q  <= flash_y_d;
        end
    end

    // Registered outputs; reset forces both approaches red and walk off at once
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_a_q <= LAMP_R;
            led_b_q <= LAMP_R;
            walk_q  <= 1'b0;
            phase_q <= ST_ALLRED;
        end else begin
            led_a_q <= lamp_a_d;
            led_b_q <= lamp_b_d;
            walk_q  <= walk_d;
            phase_q <= state_d;
        end
    end

    assign led_a    = led_a_q;
    assign led_b    = led_b_q;
    assign ped_walk = walk_q;
    assign phase    = phase_q;

endmodule

// File: tb/tb_traffic_ctrl_2way.sv
// Scoreboard bench for traffic_ctrl_2way with short phase times
// (GREEN=8 YELLOW=3 ALLRED=2 PED=5 FLASH=4). Stimulus pushes hand-derived
// per-cycle lamp expectations; a monitor pops one per falling edge.
module tb_traffic_ctrl_2way;

    localparam logic [2:0] R = 3'b110;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b011;
    localparam logic [2:0] O = 3'b111;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic       w;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       ped;
    logic       night;
    logic [2:0] led_a;
    logic [2:0] led_b;
    logic       walk;
    logic [2:0] phase;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int   n_smp;
    bit   mon_en;

    traffic_ctrl_2way #(
        .CNT_W(8), .GREEN_CYC(8), .YELLOW_CYC(3),
        .ALLRED_CYC(2), .PED_CYC(5), .FLASH_CYC(4)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .ped_req(ped), .night_mode(night),
        .led_a(led_a), .led_b(led_b), .ped_walk(walk), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @sample %0d: got %b, expected %b", name, idx, act, req);
        end
    endtask

    task automatic seg(input int n, input logic [2:0] a, input logic [2:0] b, input logic w);
        exp_t e;
        e.a = a; e.b = b; e.w = w;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Return just after sample k has been taken
    task automatic wait_after(input int k);
        while (n_smp < k + 1) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Monitor: pop one expectation per cycle and check safety invariants
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL underflow @sample %0d: no expected entry queued", n_smp);
            end else begin
                e = exp_q.pop_front();
                chk("led_a", n_smp, {1'b0, led_a}, {1'b0, e.a});
                chk("led_b", n_smp, {1'b0, led_b}, {1'b0, e.b});
                chk("ped_walk", n_smp, {3'b000, walk}, {3'b000, e.w});
            end
            // Both non-red is only legal when both are flashing Y/OFF
            chk("conflict", n_smp,
                {3'b000, (led_a != R) && (led_b != R) &&
                         !(((led_a == Y) || (led_a == O)) && (led_a == led_b))},
                4'b0000);
            chk("walk_red", n_smp, {3'b000, walk && ((led_a != R) || (led_b != R))}, 4'b0000);
            n_smp++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sample %0d reached, simulation did not finish", n_smp);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; n_smp = 0; mon_en = 1'b0;
        ped = 1'b0; night = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Normal cycle after release: samples 0..27
        seg(2, R, R, 1'b0); seg(8, G, R, 1'b0); seg(3, Y, R, 1'b0); seg(2, R, R, 1'b0);
        seg(8, R, G, 1'b0); seg(3, R, Y, 1'b0); seg(2, R, R, 1'b0);

        @(negedge clk); #1;
        chk("rst_led_a", -1, {1'b0, led_a}, {1'b0, R});
        chk("rst_led_b", -1, {1'b0, led_b}, {1'b0, R});
        chk("rst_walk", -1, {3'b000, walk}, 4'b0000);

        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Pedestrian request in A green: walk after A_YEL + all-red, then B green
        seg(8, G, R, 1'b0); seg(3, Y, R, 1'b0); seg(2, R, R, 1'b0); seg(5, R, R, 1'b1);
        wait_after(29); ped = 1'b1;
        wait_after(31); ped = 1'b0;

        // Night mode mid-B green: B phases complete, all-red, then flash Y/OFF/Y
        seg(8, R, G, 1'b0); seg(3, R, Y, 1'b0); seg(2, R, R, 1'b0);
        seg(4, Y, Y, 1'b0); seg(4, O, O, 1'b0); seg(4, Y, Y, 1'b0);
        wait_after(48); night = 1'b1;

        // Night off in flash (seen after sync latency): all-red, A green, then a walk
        seg(2, R, R, 1'b0); seg(8, G, R, 1'b0); seg(3, Y, R, 1'b0); seg(2, R, R, 1'b0);
        seg(3, R, R, 1'b1);
        wait_after(68); night = 1'b0;
        wait_after(74); ped = 1'b1;
        wait_after(76); ped = 1'b0;

        // Reset mid-walk: immediate all-red, then a clean restart from A
        seg(2, R, R, 1'b0);
        seg(2, R, R, 1'b0); seg(8, G, R, 1'b0); seg(3, Y, R, 1'b0); seg(2, R, R, 1'b0);
        seg(8, R, G, 1'b0);
        wait_after(88);
        rst_n = 1'b0;
        #1;
        chk("async_led_a", 88, {1'b0, led_a}, {1'b0, R});
        chk("async_led_b", 88, {1'b0, led_b}, {1'b0, R});
        chk("async_walk", 88, {3'b000, walk}, 4'b0000);
        wait_after(90);
        @(posedge clk); #1;
        rst_n = 1'b1;

        wait_after(113);
        mon_en = 1'b0;
        chk("queue_drained", n_smp, exp_q.size() > 0 ? 4'b0001 : 4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
